// File: rtl/hack_mem_pkg.sv
// Shared constants, region decode and display-entry type for the Hack data-memory responder.
package hack_mem_pkg;

  localparam logic [14:0] SCREEN_BASE  = 15'h4000;
  localparam int          SCREEN_WORDS = 8192;
  localparam logic [14:0] KBD_ADDR     = 15'h6000;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_SCREEN,
    REG_KBD,
    REG_NONE
  } region_t;

  typedef struct packed {
    logic [12:0] addr;
    logic [15:0] data;
  } disp_entry_t;

  // RAM addresses beyond the implemented size fall through to unmapped.
  function automatic region_t decode_region(input logic [14:0] a, input int ram_words);
    region_t r;
    if (a[14] == 1'b0)
      r = (int'(a) < ram_words) ? REG_RAM : REG_NONE;
    else if (a[13] == 1'b0)
      r = REG_SCREEN;
    else if (a == KBD_ADDR)
      r = REG_KBD;
    else
      r = REG_NONE;
    return r;
  endfunction

endpackage

// File: rtl/hack_disp_fifo.sv
// Synchronous FIFO carrying screen writes to the display controller over valid/ready.
module hack_disp_fifo
  import hack_mem_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  disp_entry_t entry,
  output logic        full,
  output logic        valid,
  input  logic        ready,
  output disp_entry_t head
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

  disp_entry_t   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == DEPTH_C);
  assign valid   = (count != '0);
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = valid & ready;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= entry;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hack_data_mem.sv
// Hack data-memory responder: RAM, screen shadow with display forwarding, keyboard register.
module hack_data_mem
  import hack_mem_pkg::*;
#(
  parameter int RAM_WORDS  = 16384,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] inM,
  output logic        stall,
  output logic        disp_valid,
  output logic [12:0] disp_addr,
  output logic [15:0] disp_data,
  input  logic        disp_ready,
  input  logic [15:0] kbd_code,
  input  logic        kbd_strobe
);

  localparam int RAW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  logic [15:0] ram    [RAM_WORDS];
  logic [15:0] screen [SCREEN_WORDS];
  logic [15:0] kbd;

  region_t     region;
  logic [12:0] scr_off;
  logic        fifo_full;
  logic        ram_we;
  logic        scr_we;
  disp_entry_t push_entry;
  disp_entry_t head;

  assign region  = decode_region(addressM, RAM_WORDS);
  assign scr_off = 13'(addressM - SCREEN_BASE);

  // Stall only ever blocks screen writes, so RAM writes need no stall gate.
  assign stall  = writeM & (region == REG_SCREEN) & fifo_full;
  assign ram_we = writeM & (region == REG_RAM);
  assign scr_we = writeM & (region == REG_SCREEN) & ~fifo_full;

  always_comb begin
    inM = 16'h0000;
    case (region)
      REG_RAM:    inM = ram[addressM[RAW-1:0]];
      REG_SCREEN: inM = screen[scr_off];
      REG_KBD:    inM = kbd;
      default:    inM = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[addressM[RAW-1:0]] <= outM;
  end

  always_ff @(posedge clk) begin
    if (scr_we) screen[scr_off] <= outM;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           kbd <= 16'h0000;
    else if (kbd_strobe) kbd <= kbd_code;
  end

  assign push_entry.addr = scr_off;
  assign push_entry.data = outM;

  hack_disp_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (scr_we),
    .entry (push_entry),
    .full  (fifo_full),
    .valid (disp_valid),
    .ready (disp_ready),
    .head  (head)
  );

  assign disp_addr = head.addr;
  assign disp_data = head.data;

endmodule

// File: tb/tb_hack_data_mem.sv
// Directed bench for hack_data_mem: RAM, screen/FIFO path, stall, keyboard, unmapped, async reset.
module tb_hack_data_mem;

  logic        clk;
  logic        reset;
  logic [14:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] inM;
  logic        stall;
  logic        disp_valid;
  logic [12:0] disp_addr;
  logic [15:0] disp_data;
  logic        disp_ready;
  logic [15:0] kbd_code;
  logic        kbd_strobe;

  int total = 0;
  int bad   = 0;

  hack_data_mem #(
    .RAM_WORDS (16384),
    .FIFO_DEPTH(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .addressM  (addressM),
    .outM      (outM),
    .writeM    (writeM),
    .inM       (inM),
    .stall     (stall),
    .disp_valid(disp_valid),
    .disp_addr (disp_addr),
    .disp_data (disp_data),
    .disp_ready(disp_ready),
    .kbd_code  (kbd_code),
    .kbd_strobe(kbd_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Step past the next rising edge; inputs are then driven well before the following one.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic head_is(input string tag, input logic [12:0] a, input logic [15:0] d);
    chk({tag, "_valid"}, {15'd0, disp_valid}, 16'h0001);
    chk({tag, "_addr"}, {3'd0, disp_addr}, {3'd0, a});
    chk({tag, "_data"}, disp_data, d);
  endtask

  initial begin
    reset      = 1'b1;
    addressM   = 15'h6000;
    outM       = 16'h0000;
    writeM     = 1'b0;
    disp_ready = 1'b0;
    kbd_code   = 16'h0000;
    kbd_strobe = 1'b0;
    #12;
    chk("rst_valid", {15'd0, disp_valid}, 16'h0000);
    chk("rst_stall", {15'd0, stall}, 16'h0000);
    chk("rst_kbd", inM, 16'h0000);
    reset = 1'b0;

    // RAM: seed, then write-and-read same cycle returns old value
    cyc(); addressM = 15'h0010; outM = 16'h1111; writeM = 1'b1;
    cyc(); outM = 16'h1234; #1;
    chk("ram_old", inM, 16'h1111);
    cyc(); writeM = 1'b0; #1;
    chk("ram_new", inM, 16'h1234);
    addressM = 15'h3FFF; outM = 16'hBEEF; writeM = 1'b1; #1;
    chk("ram_top_nostall", {15'd0, stall}, 16'h0000);
    cyc(); writeM = 1'b0; #1;
    chk("ram_top", inM, 16'hBEEF);
    addressM = 15'h0010; #1;
    chk("ram_keep", inM, 16'h1234);

    // Screen write forwarded to display
    addressM = 15'h4005; outM = 16'hFFFF; writeM = 1'b1; #1;
    chk("scr_pre_valid", {15'd0, disp_valid}, 16'h0000);
    cyc(); writeM = 1'b0; #1;
    head_is("scr1", 13'h0005, 16'hFFFF);
    chk("scr_shadow", inM, 16'hFFFF);
    cyc(); #1;
    head_is("scr1_hold", 13'h0005, 16'hFFFF);
    disp_ready = 1'b1;
    cyc(); disp_ready = 1'b0; #1;
    chk("scr_drained", {15'd0, disp_valid}, 16'h0000);

    // Seed shadow at 0x4100 and drain it
    addressM = 15'h4100; outM = 16'h0BAD; writeM = 1'b1;
    cyc(); writeM = 1'b0; disp_ready = 1'b1;
    cyc(); disp_ready = 1'b0; #1;
    chk("seed_drained", {15'd0, disp_valid}, 16'h0000);
    chk("seed_shadow", inM, 16'h0BAD);

    // Fill FIFO with four entries
    for (int i = 0; i < 4; i++) begin
      addressM = 15'h4010 + 15'(i); outM = 16'hA000 + 16'(i); writeM = 1'b1;
      cyc();
    end
    addressM = 15'h4100; outM = 16'h5555; writeM = 1'b1; #1;
    chk("full_stall", {15'd0, stall}, 16'h0001);
    chk("full_old", inM, 16'h0BAD);
    head_is("full_head", 13'h0010, 16'hA000);
    cyc(); #1;
    chk("full_stall2", {15'd0, stall}, 16'h0001);
    chk("full_noshadow", inM, 16'h0BAD);
    disp_ready = 1'b1; #1;
    chk("full_pop_stall", {15'd0, stall}, 16'h0001);
    cyc(); disp_ready = 1'b0; #1;
    chk("after_pop_stall", {15'd0, stall}, 16'h0000);
    head_is("after_pop_head", 13'h0011, 16'hA001);
    cyc(); writeM = 1'b0; #1;
    chk("late_commit", inM, 16'h5555);
    disp_ready = 1'b1; #1;
    head_is("drain1", 13'h0011, 16'hA001);
    cyc(); head_is("drain2", 13'h0012, 16'hA002);
    cyc(); head_is("drain3", 13'h0013, 16'hA003);
    cyc(); head_is("drain4", 13'h0100, 16'h5555);
    cyc(); disp_ready = 1'b0; #1;
    chk("drain_empty", {15'd0, disp_valid}, 16'h0000);

    // Keyboard
    kbd_code = 16'h0041; kbd_strobe = 1'b1;
    cyc(); kbd_strobe = 1'b0; kbd_code = 16'h7777; addressM = 15'h6000; #1;
    chk("kbd_41", inM, 16'h0041);
    outM = 16'h9999; writeM = 1'b1; #1;
    chk("kbd_wr_stall", {15'd0, stall}, 16'h0000);
    cyc(); writeM = 1'b0; #1;
    chk("kbd_wr_ignored", inM, 16'h0041);
    chk("kbd_wr_nopush", {15'd0, disp_valid}, 16'h0000);
    kbd_code = 16'h0000; kbd_strobe = 1'b1;
    cyc(); kbd_strobe = 1'b0; #1;
    chk("kbd_zero", inM, 16'h0000);

    // Unmapped
    addressM = 15'h6001; #1;
    chk("unmap_6001", inM, 16'h0000);
    addressM = 15'h7FFF; #1;
    chk("unmap_7fff", inM, 16'h0000);
    addressM = 15'h5FFF; outM = 16'hC0DE; writeM = 1'b1;
    cyc(); writeM = 1'b0; #1;
    chk("scr_last", inM, 16'hC0DE);
    disp_ready = 1'b1;
    cyc(); disp_ready = 1'b0;
    addressM = 15'h7000; outM = 16'h1234; writeM = 1'b1; #1;
    chk("unmap_wr_stall", {15'd0, stall}, 16'h0000);
    cyc(); writeM = 1'b0; #1;
    chk("unmap_wr_nopush", {15'd0, disp_valid}, 16'h0000);

    // Async reset with queued entries and a live key code
    kbd_code = 16'h0041; kbd_strobe = 1'b1;
    cyc(); kbd_strobe = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addressM = 15'h4200 + 15'(i); outM = 16'hD000 + 16'(i); writeM = 1'b1;
      cyc();
    end
    writeM = 1'b0; addressM = 15'h6000; #1;
    head_is("pre_rst", 13'h0200, 16'hD000);
    chk("pre_rst_kbd", inM, 16'h0041);
    #1;
    reset = 1'b1; #1;
    chk("arst_valid", {15'd0, disp_valid}, 16'h0000);
    chk("arst_stall", {15'd0, stall}, 16'h0000);
    chk("arst_kbd", inM, 16'h0000);
    cyc(); reset = 1'b0;
    cyc(); #1;
    chk("post_rst_valid", {15'd0, disp_valid}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
